// File: rtl/if_fetch_unit_pkg.sv
// Shared constants, bus widths and state encodings for the instruction-fetch stage.
// Optional build macro honoured by users of this package: FETCH_ALIGN_CHECK_EN.
package if_fetch_unit_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  localparam logic [INST_BUS-1:0] ZERO_WORD    = '0;
  localparam logic                CHIP_ENABLE  = 1'b1;
  localparam logic                CHIP_DISABLE = 1'b0;

  localparam logic [INST_ADDR_BUS-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_RUN  = 2'd1,
    IF_HELD = 2'd2
  } ifState_e;

  function automatic logic [INST_ADDR_BUS-1:0] alignTarget(input logic [INST_ADDR_BUS-1:0] target);
    return {target[INST_ADDR_BUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load.
// With FETCH_ALIGN_CHECK_EN defined it also carries the misaligned-fetch flag.
module if_id_reg
  import if_fetch_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     stall_i,
  input  logic                     load_i,
  input  logic [INST_ADDR_BUS-1:0] pc_i,
  input  logic [INST_BUS-1:0]      inst_i,
`ifdef FETCH_ALIGN_CHECK_EN
  input  logic                     exc_i,
  output logic                     id_exc_o,
`endif
  output logic [INST_ADDR_BUS-1:0] id_pc_o,
  output logic [INST_BUS-1:0]      id_inst_o,
  output logic                     id_valid_o
);

  logic [INST_ADDR_BUS-1:0] idPc_q, idPc_d;
  logic [INST_BUS-1:0]      idInst_q, idInst_d;
  logic                     idValid_q, idValid_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic                     idExc_q, idExc_d;
`endif

  always_comb begin
    idPc_d    = idPc_q;
    idInst_d  = idInst_q;
    idValid_d = idValid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    idExc_d   = idExc_q;
`endif
    if (flush_i) begin
      idPc_d    = '0;
      idInst_d  = ZERO_WORD;
      idValid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      idExc_d   = 1'b0;
`endif
    end else if (!stall_i && load_i) begin
      idPc_d    = pc_i;
      idInst_d  = inst_i;
      idValid_d = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      idExc_d   = exc_i;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idPc_q    <= '0;
      idInst_q  <= ZERO_WORD;
      idValid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      idExc_q   <= 1'b0;
`endif
    end else begin
      idPc_q    <= idPc_d;
      idInst_q  <= idInst_d;
      idValid_q <= idValid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      idExc_q   <= idExc_d;
`endif
    end
  end

  assign id_pc_o    = idPc_q;
  assign id_inst_o  = idInst_q;
  assign id_valid_o = idValid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign id_exc_o   = idExc_q;
`endif

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM, feeds IF/ID, parks redirects during stalls.
// Define FETCH_ALIGN_CHECK_EN to force-align redirect targets and flag them on id_exc_o.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [INST_ADDR_BUS-1:0] PC_STEP  = 32'd4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     branch_flag_i,
  input  logic [INST_ADDR_BUS-1:0] branch_target_i,
  output logic [INST_ADDR_BUS-1:0] rom_addr_o,
  output logic                     rom_ce_o,
  input  logic [INST_BUS-1:0]      rom_data_i,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                     id_exc_o,
`endif
  output logic [INST_ADDR_BUS-1:0] id_pc_o,
  output logic [INST_BUS-1:0]      id_inst_o,
  output logic                     id_valid_o
);

  ifState_e                 state_q, state_d;
  logic [INST_ADDR_BUS-1:0] pc_q, pc_d;
  logic [INST_ADDR_BUS-1:0] pendTarget_q, pendTarget_d;
  logic                     redirect;
  logic [INST_ADDR_BUS-1:0] redirectTarget;
`ifdef FETCH_ALIGN_CHECK_EN
  logic                     excPend_q, excPend_d;
`endif

  // A pending redirect is represented by IF_HELD; a live branch outranks the parked target.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pendTarget_d   = pendTarget_q;
    redirect       = 1'b0;
    redirectTarget = '0;
`ifdef FETCH_ALIGN_CHECK_EN
    excPend_d      = excPend_q;
`endif
    case (state_q)
      IF_IDLE: state_d = IF_RUN;
      IF_RUN, IF_HELD: begin
        if (stall_i) begin
          if (branch_flag_i) begin
            pendTarget_d = branch_target_i;
            state_d      = IF_HELD;
          end
        end else begin
          if (branch_flag_i) begin
            redirect       = 1'b1;
            redirectTarget = branch_target_i;
          end else if (state_q == IF_HELD) begin
            redirect       = 1'b1;
            redirectTarget = pendTarget_q;
          end
          state_d = IF_RUN;
`ifdef FETCH_ALIGN_CHECK_EN
          pc_d      = redirect ? alignTarget(redirectTarget) : pc_q + PC_STEP;
          excPend_d = redirect && (redirectTarget[1:0] != 2'b00);
`else
          pc_d      = redirect ? redirectTarget : pc_q + PC_STEP;
`endif
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IF_IDLE;
      pc_q         <= RESET_PC;
      pendTarget_q <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      excPend_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pendTarget_q <= pendTarget_d;
`ifdef FETCH_ALIGN_CHECK_EN
      excPend_q    <= excPend_d;
`endif
    end
  end

  assign rom_ce_o   = (state_q != IF_IDLE) ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr_o = (rom_ce_o == CHIP_ENABLE) ? pc_q : '0;

  if_id_reg uIfIdReg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .stall_i    (stall_i),
    .load_i     (state_q != IF_IDLE),
    .pc_i       (pc_q),
    .inst_i     (rom_data_i),
`ifdef FETCH_ALIGN_CHECK_EN
    .exc_i      (excPend_q),
    .id_exc_o   (id_exc_o),
`endif
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .id_valid_o (id_valid_o)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a combinational ROM model plus hand-computed expectations.
// The alignment scenario is exercised only when FETCH_ALIGN_CHECK_EN is defined.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        stall;
  logic        flush;
  logic        branchFlag;
  logic [31:0] branchTarget;
  logic [31:0] romAddr;
  logic        romCe;
  logic [31:0] romData;
  logic [31:0] idPc;
  logic [31:0] idInst;
  logic        idValid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        idExc;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  // Two known words at 0 and 4; elsewhere the ROM returns address + 0x1000_0000.
  always_comb begin
    case (romAddr)
      32'h0000_0000: romData = 32'h3c02_0404;
      32'h0000_0004: romData = 32'h3442_0404;
      default:       romData = romAddr + 32'h1000_0000;
    endcase
  end

  if_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rstN),
    .stall_i         (stall),
    .flush_i         (flush),
    .branch_flag_i   (branchFlag),
    .branch_target_i (branchTarget),
    .rom_addr_o      (romAddr),
    .rom_ce_o        (romCe),
    .rom_data_i      (romData),
`ifdef FETCH_ALIGN_CHECK_EN
    .id_exc_o        (idExc),
`endif
    .id_pc_o         (idPc),
    .id_inst_o       (idInst),
    .id_valid_o      (idValid)
  );

  // Drive one edge's worth of inputs, then let that edge happen and settle.
  task automatic applyStimulus(input logic rst, input logic stl, input logic fls,
                               input logic br, input logic [31:0] tgt);
    rstN         = rst;
    stall        = stl;
    flush        = fls;
    branchFlag   = br;
    branchTarget = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rstN = 1'b0; stall = 1'b0; flush = 1'b0; branchFlag = 1'b0; branchTarget = '0;

    // Reset edge
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("reset_ce",    {31'b0, romCe},   32'h0);
    checkOutput("reset_addr",  romAddr,          32'h0);
    checkOutput("reset_valid", {31'b0, idValid}, 32'h0);
    checkOutput("reset_inst",  idInst,           32'h0);
    checkOutput("reset_pc",    idPc,             32'h0);

    // IDLE -> RUN: chip enabled, IF/ID still a bubble
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("start_ce",    {31'b0, romCe},   32'h1);
    checkOutput("start_addr",  romAddr,          32'h0);
    checkOutput("start_valid", {31'b0, idValid}, 32'h0);

    // First two sequential fetches
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("fetch0_inst",  idInst,           32'h3c02_0404);
    checkOutput("fetch0_pc",    idPc,             32'h0);
    checkOutput("fetch0_valid", {31'b0, idValid}, 32'h1);
    checkOutput("fetch0_addr",  romAddr,          32'h4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("fetch4_inst",  idInst,           32'h3442_0404);
    checkOutput("fetch4_pc",    idPc,             32'h4);
    checkOutput("fetch4_addr",  romAddr,          32'h8);

    // Three stalled edges at pc 0x8
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_addr", romAddr, 32'h8);
      checkOutput("stall_inst", idInst,  32'h3442_0404);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("resume_pc",   idPc,    32'h8);
    checkOutput("resume_inst", idInst,  32'h1000_0008);
    checkOutput("resume_addr", romAddr, 32'hC);

    // Advance to 0x1C, then branch to 0x30 unstalled
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("pre_branch_addr", romAddr, 32'h1C);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h30);
    checkOutput("branch_addr", romAddr, 32'h30);
    checkOutput("branch_idpc", idPc,    32'h1C);

    // Branch to 0x38 during a two-edge stall, released afterwards
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h38);
    checkOutput("held_addr0", romAddr, 32'h30);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("held_addr1", romAddr, 32'h30);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("held_release_addr", romAddr, 32'h38);
    checkOutput("held_release_idpc", idPc,    32'h30);

    // Newer branch during the stall overrides the parked one
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h38);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("override_addr", romAddr, 32'h10);
    checkOutput("override_idpc", idPc,    32'h38);

    // A live branch on the release edge beats the parked target
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h50);
    checkOutput("live_beats_held_addr", romAddr, 32'h50);
    checkOutput("live_beats_held_inst", idInst,  32'h1000_0010);

    // Flush with stall: bubble, pc holds
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("flush_stall_valid", {31'b0, idValid}, 32'h0);
    checkOutput("flush_stall_inst",  idInst,           32'h0);
    checkOutput("flush_stall_pc",    idPc,             32'h0);
    checkOutput("flush_stall_addr",  romAddr,          32'h50);

    // Flush alone: bubble, pc still advances
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("flush_valid", {31'b0, idValid}, 32'h0);
    checkOutput("flush_addr",  romAddr,          32'h54);

    // PC wrap at the top of the address space
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_pre_addr", romAddr, 32'hFFFF_FFFC);
    checkOutput("wrap_pre_idpc", idPc,    32'h54);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr", romAddr, 32'h0);
    checkOutput("wrap_idpc", idPc,    32'hFFFF_FFFC);
    checkOutput("wrap_inst", idInst,  32'h0FFF_FFFC);

    // Misaligned redirect target 0x26
`ifdef FETCH_ALIGN_CHECK_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h26);
    checkOutput("align_addr",  romAddr,        32'h24);
    checkOutput("align_exc0",  {31'b0, idExc}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("align_exc1",  {31'b0, idExc}, 32'h1);
    checkOutput("align_idpc",  idPc,           32'h24);
    checkOutput("align_valid", {31'b0, idValid}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("align_exc2",  {31'b0, idExc}, 32'h0);
`else
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h26);
    checkOutput("misalign_addr", romAddr, 32'h26);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("misalign_idpc", idPc,    32'h26);
    checkOutput("misalign_next", romAddr, 32'h2A);
`endif

    // Reset while a redirect is parked discards it
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h60);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("midreset_ce",    {31'b0, romCe},   32'h0);
    checkOutput("midreset_addr",  romAddr,          32'h0);
    checkOutput("midreset_valid", {31'b0, idValid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("midreset_resume_addr", romAddr, 32'h4);
    checkOutput("midreset_resume_inst", idInst,  32'h3c02_0404);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the five-stage pipeline; the requesting side of the instruction-memory interface.
- Owns the PC and drives the ROM address and chip-enable.
- Captures the returned word (combinational, same-cycle ROM) into the IF/ID pipeline register.
- Handles pipeline stall, IF/ID flush and branch redirect; a redirect that arrives during a stall is held until the stall clears.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall_i  in  1  hold PC and IF/ID contents.
- flush_i  in  1  load a bubble into IF/ID.
- branch_flag_i  in  1  redirect request from ID.
- branch_target_i  in  32  redirect address.
- rom_addr_o  out  32  instruction address (`INST_ADDR_BUS`).
- rom_ce_o  out  1  ROM chip enable (`CHIP_ENABLE`/`CHIP_DISABLE`).
- rom_data_i  in  32  instruction word (`INST_BUS`).
- id_pc_o  out  32  PC of the instruction held in IF/ID.
- id_inst_o  out  32  instruction held in IF/ID.
- id_valid_o  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC, rom_ce_o=`CHIP_DISABLE`, state=IDLE, pend=0.
  - id_pc_o=0, id_inst_o=`ZERO_WORD`, id_valid_o=0.
  - Reset mid-operation discards any pending redirect and IF/ID contents.
- rom_addr_o = pc when ce is enabled, else 0. Driven combinationally from the pc register.
- IDLE: on the first edge with rst_n=1, go to RUN and set ce=`CHIP_ENABLE`; pc is unchanged. IF/ID stays a bubble for that edge.
- RUN, per edge, with priority flush > stall > redirect > sequential:
  - flush_i=1:
    - IF/ID <= bubble (inst=`ZERO_WORD`, pc=0, valid=0).
    - PC update still follows the stall/redirect rules below; flush does not freeze the PC.
  - stall_i=1 (no flush):
    - pc and IF/ID hold.
    - If branch_flag_i=1: pend_target<=branch_target_i, pend=1, state=HELD. A newer branch during HELD overwrites pend_target.
  - No stall:
    - IF/ID <= {pc, rom_data_i, valid=1}.
    - pc <= branch_flag_i ? branch_target_i : pc+PC_STEP.
- HELD state (redirect pending):
  - Same as RUN, except on the first unstalled edge pc <= (branch_flag_i ? branch_target_i : pend_target).
  - That edge clears pend and returns to RUN.
  - A live branch_flag_i beats the held target.
- Arithmetic: pc+PC_STEP is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- Latency: the instruction at address A appears on id_inst_o one edge after rom_addr_o=A with no stall.
- Simultaneous flush+stall: IF/ID is bubbled and pc holds.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output id_exc_o (1 bit, reset 0).
  - A redirect target (live or held) with bits[1:0]≠0 is force-aligned to target & ~3 for the PC.
  - The next IF/ID load sets id_exc_o=1 with valid=1; id_exc_o clears on the following IF/ID load or flush.
- Undefined: the port is absent and targets are used unmodified; a misaligned address goes straight to the ROM.

Decomposition:
- Shared header DEFINE.v: `INST_ADDR_BUS`, `INST_BUS`, `ZERO_WORD`, `CHIP_ENABLE`/`CHIP_DISABLE`, and the new state encodings `IF_IDLE`/`IF_RUN`/`IF_HELD` and `RESET_PC`.
- Sub-module if_id_reg: the IF/ID pipeline register, handling the flush/stall/load priority. The PC/FSM logic stays in if_fetch_unit.

Test Plan:
- Reset then release, no stall, ROM model returns 0x3c020404@0 and 0x34420404@4 -> rom_ce_o=0 at cycle 0, 1 at cycle 1; id_inst_o=0x3c020404 with id_pc_o=0, then 0x34420404 with id_pc_o=4.
- stall_i=1 for 3 cycles at pc=0x8 -> rom_addr_o stays 0x8; id_inst_o holds 0x34420404; resumes at 0x8 then 0xC.
- branch_flag_i=1, target=0x30 while unstalled at pc=0x1C -> next rom_addr_o=0x30; id_pc_o=0x1C loaded the same edge.
- branch at target 0x38 during a 2-cycle stall, then unstall -> pc=0x38 on the first unstalled edge. A second branch to 0x10 during the stall overrides it (pc=0x10).
- flush_i=1 with stall_i=1 -> id_valid_o=0, id_inst_o=0, pc unchanged. Run with pc=0xFFFF_FFFC -> next pc=0x0.
- With FETCH_ALIGN_CHECK_EN: branch target 0x26 -> rom_addr_o=0x24 and id_exc_o=1 for exactly one IF/ID load.
